// File: rtl/demux_stream_pkg.sv
// rtl/demux_stream_pkg.sv - shared types and constants for the packet demultiplexer
package demux_stream_pkg;

    localparam int NUM_CH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE0 = 2'd1,
        ROUTE1 = 2'd2
    } route_state_t;

endpackage

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - one-entry valid/ready register holding a data beat and its last flag
module stream_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             out_ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        // a load in the same cycle as a drain wins, so the slice stays full
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/demux1to2_stream.sv
// rtl/demux1to2_stream.sv - packet-aware 1-to-2 stream demultiplexer with per-channel packet counters
module demux1to2_stream
    import demux_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    route_state_t      state_q, state_d;
    logic              dest_ch;
    logic              accept;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] sl_valid;
    logic [NUM_CH-1:0] sl_ready;
    logic [NUM_CH-1:0] sl_last;
    logic [WIDTH-1:0]  sl_data [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];

    assign sl_ready = {out1_ready, out0_ready};

    // in_sel only matters on a packet's first beat; mid-packet the route is locked
    always_comb begin
        dest_ch = 1'b0;
        case (state_q)
            IDLE:    dest_ch = in_sel;
            ROUTE0:  dest_ch = 1'b0;
            ROUTE1:  dest_ch = 1'b1;
            default: dest_ch = 1'b0;
        endcase
    end

    assign in_ready = !sl_valid[dest_ch] || sl_ready[dest_ch];
    assign accept   = in_valid && in_ready;
    assign load     = {accept && dest_ch, accept && !dest_ch};

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (in_last)      state_d = IDLE;
            else if (dest_ch) state_d = ROUTE1;
            else              state_d = ROUTE0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        stream_reg_slice #(.WIDTH(WIDTH)) u_slice (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (load[c]),
            .data_i      (in_data),
            .last_i      (in_last),
            .out_ready_i (sl_ready[c]),
            .valid_o     (sl_valid[c]),
            .data_o      (sl_data[c]),
            .last_o      (sl_last[c])
        );

        always_ff @(posedge clk) begin
            if (!rst_n)
                cnt_q[c] <= '0;
            else if (sl_valid[c] && sl_ready[c] && sl_last[c])
                cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end
    end

    assign out0_valid = sl_valid[0];
    assign out0_data  = sl_data[0];
    assign out0_last  = sl_last[0];
    assign out1_valid = sl_valid[1];
    assign out1_data  = sl_data[1];
    assign out1_last  = sl_last[1];
    assign pkt_cnt0   = cnt_q[0];
    assign pkt_cnt1   = cnt_q[1];

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb/tb_demux1to2_stream.sv - scoreboard bench for the packet demultiplexer
module tb_demux1to2_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, in_sel;
    logic [7:0]  in_data;
    logic        out0_valid, out0_ready, out0_last;
    logic [7:0]  out0_data;
    logic        out1_valid, out1_ready, out1_last;
    logic [7:0]  out1_data;
    logic [15:0] pkt_cnt0, pkt_cnt1;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp0[$];
    logic [8:0] exp1[$];
    logic       route_act = 1'b0;
    logic       route_ch  = 1'b0;
    logic       mon_en    = 1'b1;

    always #5 clk = ~clk;

    demux1to2_stream #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_sel     (in_sel),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one beat; the expected output is queued at the negedge where it is accepted
    task automatic send(input logic [7:0] d, input logic l, input logic s);
        int  n = 0;
        logic dst;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_sel   = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("send_accept", {31'd0, in_ready}, 32'd1);
        end else begin
            dst = route_act ? route_ch : s;
            if (dst) exp1.push_back({l, d});
            else     exp0.push_back({l, d});
            route_act = !l;
            route_ch  = dst;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_en) begin
            if (out0_valid && out0_ready) begin
                if (exp0.size() == 0) chk("out0_unexpected", {31'd0, out0_valid}, 32'd0);
                else chk("out0_beat", {23'd0, out0_last, out0_data}, {23'd0, exp0.pop_front()});
            end
            if (out1_valid && out1_ready) begin
                if (exp1.size() == 0) chk("out1_unexpected", {31'd0, out1_valid}, 32'd0);
                else chk("out1_beat", {23'd0, out1_last, out1_data}, {23'd0, exp1.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h00; in_last = 1'b0; in_sel = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;

        // reset held two clocks with in_valid asserted
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("rst_out0_valid_rel", {31'd0, out0_valid}, 32'd0);
        chk("rst_out1_valid_rel", {31'd0, out1_valid}, 32'd0);
        chk("rst_cnt0", {16'd0, pkt_cnt0}, 32'd0);
        chk("rst_cnt1", {16'd0, pkt_cnt1}, 32'd0);
        @(posedge clk);
        #1;

        // 3-beat packet to channel 1 with one-cycle latency checks
        out0_ready = 1'b1; out1_ready = 1'b1;
        send(8'hA1, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_a1_valid", {31'd0, out1_valid}, 32'd1);
        chk("lat_a1_data", {24'd0, out1_data}, 32'hA1);
        @(posedge clk); #1;
        send(8'hA2, 1'b0, 1'b1);
        send(8'hA3, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_a3_last", {31'd0, out1_last}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("ch1_cnt1", {16'd0, pkt_cnt1}, 32'd1);
        chk("ch1_cnt0", {16'd0, pkt_cnt0}, 32'd0);

        // in_sel toggles mid-packet; whole packet stays on out0
        send(8'h10, 1'b0, 1'b0);
        send(8'h11, 1'b0, 1'b1);
        send(8'h12, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("tog_cnt0", {16'd0, pkt_cnt0}, 32'd1);
        chk("tog_cnt1", {16'd0, pkt_cnt1}, 32'd1);

        // back-pressure on out0, then simultaneous drain and fill
        out0_ready = 1'b0;
        send(8'h20, 1'b0, 1'b0);
        fork
            send(8'h21, 1'b1, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_hold_valid", {31'd0, out0_valid}, 32'd1);
                    chk("bp_hold_data", {24'd0, out0_data}, 32'h20);
                end
                @(posedge clk);
                #1;
                out0_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        chk("bp_cnt0", {16'd0, pkt_cnt0}, 32'd2);

        // stalled out0 must not block a single-beat packet to out1
        out0_ready = 1'b0;
        send(8'h30, 1'b1, 1'b0);
        send(8'h55, 1'b1, 1'b1);
        @(negedge clk);
        chk("ind_out0_held", {31'd0, out0_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("ind_cnt1", {16'd0, pkt_cnt1}, 32'd2);
        chk("ind_cnt0_stalled", {16'd0, pkt_cnt0}, 32'd2);
        out0_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ind_cnt0", {16'd0, pkt_cnt0}, 32'd3);

        // reset in the middle of a 4-beat channel-1 packet
        send(8'hB1, 1'b0, 1'b1);
        send(8'hB2, 1'b0, 1'b1);
        out1_ready = 1'b0;
        rst_n = 1'b0;
        exp1.delete();
        route_act = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("mid_rst_out1_valid", {31'd0, out1_valid}, 32'd0);
        rst_n = 1'b1;
        out1_ready = 1'b1;
        send(8'hC0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_out1_idle", {31'd0, out1_valid}, 32'd0);
        chk("mid_rst_cnt0", {16'd0, pkt_cnt0}, 32'd1);
        chk("mid_rst_cnt1", {16'd0, pkt_cnt1}, 32'd0);

        // preload pkt_cnt0 to 0xFFFF with single-beat packets, then wrap
        mon_en   = 1'b0;
        in_valid = 1'b1; in_last = 1'b1; in_sel = 1'b0; in_data = 8'h66;
        repeat (65534) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("wrap_pre", {16'd0, pkt_cnt0}, 32'h0000FFFF);
        mon_en = 1'b1;
        send(8'h77, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("wrap_zero", {16'd0, pkt_cnt0}, 32'd0);

        chk("q0_empty", exp0.size(), 32'd0);
        chk("q1_empty", exp1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
